// File: rtl/seq_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : seq_bin_to_bcd
//  Purpose  : Multi-channel sequential binary-to-BCD converter. A single
//             shift-and-add-3 (double-dabble) engine converts one bit per
//             clock and walks the channels one after another. Results are
//             published to bcd_out_o/ovf_o all at once, together with done_o.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i      : system clock, rising edge
//    rst_ni     : asynchronous active-low reset
//    start_i    : conversion request, accepted only while idle
//    bin_in_i   : N_CH packed binary channels, channel 0 in the LSBs
//    busy_o     : high while a conversion is in progress
//    done_o     : one-cycle pulse when bcd_out_o/ovf_o are updated
//    bcd_out_o  : packed BCD, channel c digit d at [(c*DIGITS+d)*4 +: 4]
//    ovf_o      : per-channel flag, value exceeds 10^DIGITS-1 (saturated)
// ----------------------------------------------------------------------------
//  Build option
//    LEAD_ZERO_BLANK_EN : when defined, leading zero digits (never the ones
//                         digit, never a saturated result) are stored as 4'hF.
// ============================================================================
module seq_bin_to_bcd #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int N_CH   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [N_CH*BIN_W-1:0]      bin_in_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [N_CH*DIGITS*4-1:0]   bcd_out_o,
  output logic [N_CH-1:0]            ovf_o
);

  localparam int SCR_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CNT_W-1:0] C_BITCNT_INIT = CNT_W'(BIN_W - 1);
  localparam logic [CH_W-1:0]  C_LAST_CH     = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_STORE = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [N_CH*BIN_W-1:0]     shadow_q, shadow_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [BIN_W-1:0]          shreg_q, shreg_d;
  logic [SCR_W-1:0]          scratch_q, scratch_d;
  logic [CNT_W-1:0]          bitcnt_q, bitcnt_d;
  logic                      ovf_bit_q, ovf_bit_d;
  logic [SCR_W-1:0]          res_q [N_CH];
  logic [SCR_W-1:0]          res_d [N_CH];
  logic [N_CH-1:0]           res_ovf_q, res_ovf_d;
  logic [N_CH*SCR_W-1:0]     bcd_out_q, bcd_out_d;
  logic [N_CH-1:0]           ovf_q, ovf_d;
  logic                      done_q, done_d;

  logic [BIN_W-1:0]          ch_bin_w [N_CH];
  logic [SCR_W-1:0]          scr_adj_w;
  logic [SCR_W-1:0]          store_val_w;

  // Channel view of the captured inputs.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch_unpack
    assign ch_bin_w[c] = shadow_q[c*BIN_W +: BIN_W];
  end

  // Add-3 correction applied to every scratch digit before the shift.
  always_comb begin
    scr_adj_w = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[d*4 +: 4] >= 4'd5) begin
        scr_adj_w[d*4 +: 4] = scratch_q[d*4 +: 4] + 4'd3;
      end
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  // Replace zeros above the most significant nonzero digit with the blank code.
  function automatic logic [SCR_W-1:0] blank_lead(input logic [SCR_W-1:0] v);
    logic [SCR_W-1:0] r;
    logic             lead;
    r    = v;
    lead = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (v[d*4 +: 4] == 4'h0)) begin
        r[d*4 +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction
`endif

  always_comb begin
    store_val_w = scratch_q;
    if (ovf_bit_q) begin
      store_val_w = {DIGITS{4'h9}};
    end else begin
`ifdef LEAD_ZERO_BLANK_EN
      store_val_w = blank_lead(scratch_q);
`else
      store_val_w = scratch_q;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    ch_d      = ch_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    bitcnt_d  = bitcnt_q;
    ovf_bit_d = ovf_bit_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    bcd_out_d = bcd_out_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          shadow_d = bin_in_i;
          ch_d     = '0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        shreg_d   = ch_bin_w[ch_q];
        scratch_d = '0;
        ovf_bit_d = 1'b0;
        bitcnt_d  = C_BITCNT_INIT;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        // {scratch, shreg} shifted left by one; the bit dropped off the top
        // digit means the value needs more digits than are available.
        scratch_d = {scr_adj_w[SCR_W-2:0], shreg_q[BIN_W-1]};
        shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
        if (scr_adj_w[SCR_W-1]) begin
          ovf_bit_d = 1'b1;
        end
        if (bitcnt_q == '0) begin
          state_d = S_STORE;
        end else begin
          bitcnt_d = bitcnt_q - 1'b1;
        end
      end

      S_STORE: begin
        res_d[ch_q]     = store_val_w;
        res_ovf_d[ch_q] = ovf_bit_q;
        if (ch_q == C_LAST_CH) begin
          // Publish every channel together, including the one stored now.
          for (int c = 0; c < N_CH; c++) begin
            bcd_out_d[c*SCR_W +: SCR_W] = res_d[c];
          end
          ovf_d   = res_ovf_d;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      ch_q      <= '0;
      shreg_q   <= '0;
      scratch_q <= '0;
      bitcnt_q  <= '0;
      ovf_bit_q <= 1'b0;
      res_q     <= '{default: '0};
      res_ovf_q <= '0;
      bcd_out_q <= '0;
      ovf_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      ch_q      <= ch_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      bitcnt_q  <= bitcnt_d;
      ovf_bit_q <= ovf_bit_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
      bcd_out_q <= bcd_out_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign bcd_out_o = bcd_out_q;
  assign ovf_o     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_bin_to_bcd
//  Purpose  : Directed self-checking bench for seq_bin_to_bcd. Instance u_dut
//             uses the default parameters; u_dut2 uses DIGITS=2 to exercise
//             overflow saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_bin_to_bcd;

  logic        clk;
  logic        rst_n;

  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic [1:0]  ovf;

  logic        start2;
  logic [15:0] bin2;
  logic        busy2;
  logic        done2;
  logic [15:0] bcd2;
  logic [1:0]  ovf2;

  int checks   = 0;
  int failures = 0;

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3), .N_CH(2)) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .bin_in_i (bin_in),
    .busy_o   (busy),
    .done_o   (done),
    .bcd_out_o(bcd),
    .ovf_o    (ovf)
  );

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(2), .N_CH(2)) u_dut2 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start2),
    .bin_in_i (bin2),
    .busy_o   (busy2),
    .done_o   (done2),
    .bcd_out_o(bcd2),
    .ovf_o    (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed 3-digit results, with and without leading-zero blanking.
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [11:0] E0 = 12'hFF0, E7 = 12'hFF7, E9 = 12'hFF9, E10 = 12'hF10;
  localparam logic [11:0] E13 = 12'hF13, E42 = 12'hF42, E64 = 12'hF64, E99 = 12'hF99;
  localparam logic [7:0]  E5_2D = 8'hF5;
`else
  localparam logic [11:0] E0 = 12'h000, E7 = 12'h007, E9 = 12'h009, E10 = 12'h010;
  localparam logic [11:0] E13 = 12'h013, E42 = 12'h042, E64 = 12'h064, E99 = 12'h099;
  localparam logic [7:0]  E5_2D = 8'h05;
`endif

  // Divide/modulo reference for the exhaustive sweep.
  function automatic logic [11:0] ref3(input int v);
    int h, t, o;
    logic [11:0] r;
    h = (v / 100) % 10;
    t = (v / 10) % 10;
    o = v % 10;
    r = {4'(h), 4'(t), 4'(o)};
`ifdef LEAD_ZERO_BLANK_EN
    if (h == 0) begin
      r[11:8] = 4'hF;
      if (t == 0) r[7:4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until the selected instance raises done; returns edges consumed.
  task automatic wait_done(input bit which, output int lat);
    lat = 0;
    while (lat < 100) begin
      tick();
      lat++;
      if ((which ? done2 : done) === 1'b1) break;
    end
  endtask

  task automatic pulse_start(input logic [15:0] data);
    bin_in = data;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  int lat;
  int bcnt;
  int seen;

  initial begin
    start  = 1'b0;
    start2 = 1'b0;
    bin_in = '0;
    bin2   = '0;
    rst_n  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd),  32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    check("rst_bcd2", 32'(bcd2), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic conversion: ch1=13, ch0=255; inputs scrambled after the start edge
    pulse_start({8'd13, 8'd255});
    bin_in = 16'hA5A5;
    bcnt = busy ? 1 : 0;
    lat  = 0;
    while (lat < 100) begin
      tick();
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
    check("basic_latency", 32'(lat), 32'd20);
    check("basic_busy_cycles", 32'(bcnt), 32'd20);
    check("basic_bcd", 32'(bcd), {8'h0, E13, 12'h255});
    check("basic_ovf", 32'(ovf), 32'd0);
    check("basic_busy_in_done", 32'(busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("basic_bcd_hold", 32'(bcd), {8'h0, E13, 12'h255});

    // start while busy is ignored
    pulse_start({8'd42, 8'd7});
    repeat (5) tick();
    pulse_start({8'd200, 8'd201});
    wait_done(1'b0, lat);
    check("ignore_latency", 32'(lat), 32'd14);
    check("ignore_bcd", 32'(bcd), {8'h0, E42, E7});

    // start during the done cycle is accepted
    pulse_start({8'd128, 8'd64});
    check("b2b_accept_busy", 32'(busy), 32'd1);
    wait_done(1'b0, lat);
    check("b2b_latency", 32'(lat), 32'd20);
    check("b2b_bcd", 32'(bcd), {8'h0, 12'h128, E64});

    // Reset mid-SHIFT: outputs clear immediately, no done afterwards
    tick();
    pulse_start({8'd250, 8'd150});
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd",  32'(bcd),  32'd0);
    check("midrst_ovf",  32'(ovf),  32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    // Boundaries
    pulse_start({8'd9, 8'd0});
    wait_done(1'b0, lat);
    check("bnd_0_9", 32'(bcd), {8'h0, E9, E0});
    tick();
    pulse_start({8'd99, 8'd10});
    wait_done(1'b0, lat);
    check("bnd_10_99", 32'(bcd), {8'h0, E99, E10});
    tick();
    pulse_start({8'd255, 8'd100});
    wait_done(1'b0, lat);
    check("bnd_100_255", 32'(bcd), {8'h0, 12'h255, 12'h100});
    check("bnd_ovf", 32'(ovf), 32'd0);

    // Exhaustive sweep of all 8-bit values against divide/modulo
    for (int v = 0; v < 256; v += 2) begin
      tick();
      pulse_start({8'(v + 1), 8'(v)});
      wait_done(1'b0, lat);
      check("sweep_ch0", 32'(bcd[11:0]), 32'(ref3(v)));
      check("sweep_ch1", 32'(bcd[23:12]), 32'(ref3(v + 1)));
    end

    // Overflow with two digits: ch0=200 saturates, ch1=99 fits
    bin2   = {8'd99, 8'd200};
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_done(1'b1, lat);
    check("ovf_latency", 32'(lat), 32'd20);
    check("ovf_bcd", 32'(bcd2), 32'h9999);
    check("ovf_flags", 32'(ovf2), 32'd1);
    tick();
    bin2   = {8'd100, 8'd5};
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_done(1'b1, lat);
    check("ovf2_bcd", 32'(bcd2), {16'h0, 8'h99, E5_2D});
    check("ovf2_flags", 32'(ovf2), 32'd2);

`ifdef LEAD_ZERO_BLANK_EN
    tick();
    pulse_start({8'd0, 8'd7});
    wait_done(1'b0, lat);
    check("blank_7_0", 32'(bcd), {8'h0, 12'hFF0, 12'hFF7});
    tick();
    pulse_start({8'd0, 8'd105});
    wait_done(1'b0, lat);
    check("blank_105", 32'(bcd[11:0]), 32'h105);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
